// File: rtl/acc_fifo_sched_pkg.sv
// acc_sched_pkg: pop-side FSM encoding and default sizing shared by the accumulator scheduler
package acc_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, OUT = 2'd2} state_t;
  localparam int DefDataWidth = 32;
  localparam int DefNumReq = 4;
  localparam int DefAccLen = 4;
endpackage

// File: rtl/acc_fifo_sched_if.sv
// acc_fifo_sched_if: requester, FIFO write/read and result handshake bundle
interface acc_fifo_sched_if
  import acc_sched_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int NumReq = DefNumReq
);
  logic [NumReq-1:0] Req;
  logic [NumReq*DataWidth-1:0] ReqData;
  logic [NumReq-1:0] Grant;
  logic FifoPush;
  logic [DataWidth-1:0] FifoDataIn;
  logic FifoFull;
  logic FifoPop;
  logic FifoEmpty;
  logic [DataWidth-1:0] FifoDataOut;
  logic ResValid;
  logic [DataWidth-1:0] ResData;
  logic ResReady;
  modport master (
    output Req, ReqData, FifoFull, FifoEmpty, FifoDataOut, ResReady,
    input Grant, FifoPush, FifoDataIn, FifoPop, ResValid, ResData
  );
  modport slave (
    input Req, ReqData, FifoFull, FifoEmpty, FifoDataOut, ResReady,
    output Grant, FifoPush, FifoDataIn, FifoPop, ResValid, ResData
  );
endinterface

// File: rtl/acc_fifo_sched_arb.sv
// rr_arbiter: one-hot grant to the first request at or above Ptr, wrapping around
module rr_arbiter #(
  parameter int NumReq = 4,
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] Req,
  input  logic [PtrW-1:0]   Ptr,
  output logic [NumReq-1:0] Grant
);
  int j;
  always_comb begin
    Grant = '0;
    j = 0;
    // scan from farthest to nearest so the nearest hit wins
    for (int k = NumReq - 1; k >= 0; k--) begin
      j = int'(Ptr) + k;
      j = (j >= NumReq) ? j - NumReq : j;
      if (Req[j]) begin
        Grant = '0;
        Grant[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/acc_fifo_sched.sv
// acc_fifo_sched: round-robin push into an external FIFO and AccLen-entry summing pop side
module acc_fifo_sched
  import acc_sched_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int NumReq = DefNumReq,
  parameter int AccLen = DefAccLen
) (
  input logic clk,
  input logic aclr,
  input logic clk_en,
  acc_fifo_sched_if.slave bus
);
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  logic act;
  logic [PtrW-1:0] ptr, gidx;
  logic [NumReq-1:0] arb_grant;
  logic [DataWidth-1:0] din, sum, sum_nx;
  logic [7:0] cnt, cnt_nx;
  logic pop;
  state_t state, state_nx;
  // reset also gates the combinational strobes so nothing fires while aclr is low
  assign act = clk_en && aclr;
  rr_arbiter #(.NumReq(NumReq)) u_arb (.Req(bus.Req), .Ptr(ptr), .Grant(arb_grant));
  assign bus.Grant = (act && !bus.FifoFull) ? arb_grant : '0;
  assign bus.FifoPush = |bus.Grant;
  assign bus.FifoDataIn = din;
  always_comb begin
    din = '0;
    gidx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (bus.Grant[i]) begin
        din = bus.ReqData[i*DataWidth +: DataWidth];
        gidx = PtrW'(i);
      end
    end
  end
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) ptr <= '0;
    else if (bus.FifoPush) ptr <= (gidx == PtrW'(NumReq - 1)) ? '0 : gidx + 1'b1;
  end
  always_comb begin
    state_nx = state;
    sum_nx = sum;
    cnt_nx = cnt;
    pop = 1'b0;
    case (state)
      IDLE: if (act && !bus.FifoEmpty) begin
        pop = 1'b1;
        sum_nx = bus.FifoDataOut;
        cnt_nx = 8'd1;
        state_nx = (AccLen == 1) ? OUT : ACC;
      end
      ACC: if (act && !bus.FifoEmpty) begin
        pop = 1'b1;
        sum_nx = sum + bus.FifoDataOut;
        cnt_nx = cnt + 8'd1;
        state_nx = (cnt_nx == 8'(AccLen)) ? OUT : ACC;
      end
      OUT: if (act && bus.ResReady) begin
        state_nx = IDLE;
        sum_nx = '0;
        cnt_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state <= IDLE;
      sum <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      sum <= sum_nx;
      cnt <= cnt_nx;
    end
  end
  assign bus.FifoPop = pop;
  assign bus.ResValid = (state == OUT);
  assign bus.ResData = (state == OUT) ? sum : '0;
endmodule

// File: tb/tb_acc_fifo_sched.sv
// tb_acc_fifo_sched: directed and random checks of the scheduler against a queue-based model
module tb_acc_fifo_sched;
  localparam int DW = 32;
  localparam int N = 4;
  localparam int ACC = 4;
  localparam int DEPTH = 8;
  logic clk, aclr, clk_en, force_full;
  logic [N-1:0] rq, last_grant;
  logic [DW-1:0] last_din, msum;
  logic last_push, last_pop, m_out;
  int mptr, mcnt, checks, passes;
  logic [DW-1:0] q[$];
  logic [N-1:0] exp_seq[5];
  acc_fifo_sched_if #(.DataWidth(DW), .NumReq(N)) bus ();
  acc_fifo_sched #(.DataWidth(DW), .NumReq(N), .AccLen(ACC)) dut (
    .clk(clk), .aclr(aclr), .clk_en(clk_en), .bus(bus)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic fifo_drive();
    bus.FifoEmpty = (q.size() == 0);
    bus.FifoDataOut = (q.size() > 0) ? q[0] : '0;
    bus.FifoFull = force_full || (q.size() >= DEPTH);
  endtask
  // one clock: check outputs against the model, advance model, then emulate the FIFO
  task automatic tick();
    logic [N-1:0] eg;
    logic ep;
    int g;
    bus.Req = rq;
    fifo_drive();
    #1;
    eg = '0;
    g = -1;
    if (clk_en && aclr && !bus.FifoFull)
      for (int k = 0; k < N; k++)
        if (g < 0 && rq[(mptr + k) % N]) g = (mptr + k) % N;
    if (g >= 0) eg[g] = 1'b1;
    ep = clk_en && aclr && !m_out && (q.size() > 0);
    chk("grant", bus.Grant, eg);
    chk("push", bus.FifoPush, g >= 0);
    chk("din", bus.FifoDataIn, (g >= 0) ? bus.ReqData[g*DW +: DW] : '0);
    chk("pop", bus.FifoPop, ep);
    chk("valid", bus.ResValid, m_out);
    if (m_out) chk("resdata", bus.ResData, msum);
    last_grant = bus.Grant;
    last_din = bus.FifoDataIn;
    last_push = bus.FifoPush;
    last_pop = bus.FifoPop;
    if (clk_en && aclr) begin
      if (g >= 0) mptr = (g + 1) % N;
      if (m_out) begin
        if (bus.ResReady) begin
          m_out = 0;
          msum = '0;
          mcnt = 0;
        end
      end else if (ep) begin
        msum = msum + q[0];
        mcnt++;
        if (mcnt == ACC) m_out = 1;
      end
    end
    @(posedge clk);
    #1;
    if (last_pop) void'(q.pop_front());
    if (last_push) q.push_back(last_din);
    fifo_drive();
    @(negedge clk);
  endtask
  task automatic do_reset();
    aclr = 0;
    #1;
    chk("rst_grant", bus.Grant, 0);
    chk("rst_push", bus.FifoPush, 0);
    chk("rst_pop", bus.FifoPop, 0);
    chk("rst_valid", bus.ResValid, 0);
    chk("rst_data", bus.ResData, 0);
    q.delete();
    fifo_drive();
    mptr = 0;
    msum = '0;
    mcnt = 0;
    m_out = 0;
    @(negedge clk);
    aclr = 1;
  endtask
  task automatic push1(logic [DW-1:0] v);
    rq = 4'b0001;
    bus.ReqData[0 +: DW] = v;
    tick();
    rq = '0;
  endtask
  task automatic wait_valid(int bound);
    int n = 0;
    rq = '0;
    while (!bus.ResValid && n < bound) begin
      tick();
      n++;
    end
    chk("res_timeout", bus.ResValid, 1);
  endtask
  initial begin
    checks = 0;
    passes = 0;
    aclr = 1;
    clk_en = 1;
    force_full = 0;
    rq = '0;
    bus.Req = '0;
    bus.ReqData = '0;
    bus.ResReady = 1;
    fifo_drive();
    @(negedge clk);
    rq = 4'b1111;
    bus.Req = rq;
    bus.FifoEmpty = 0;
    do_reset();
    // full round-robin rotation
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < N; i++) bus.ReqData[i*DW +: DW] = 100 + i;
    for (int i = 0; i < 5; i++) begin
      rq = 4'b1111;
      tick();
      chk("rr_seq", last_grant, exp_seq[i]);
    end
    rq = '0;
    do_reset();
    // sparse requests skip idle requesters
    exp_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b0000, 4'b0000};
    for (int i = 0; i < N; i++) bus.ReqData[i*DW +: DW] = 32'hA0 + i;
    for (int i = 0; i < 3; i++) begin
      rq = 4'b1010;
      tick();
      chk("sparse_seq", last_grant, exp_seq[i]);
      chk("sparse_din", last_din, (i == 1) ? 32'hA3 : 32'hA1);
    end
    rq = '0;
    do_reset();
    // full FIFO blocks grants and freezes the pointer
    force_full = 1;
    rq = 4'b0001;
    tick();
    chk("full_grant", last_grant, 0);
    tick();
    chk("full_grant2", last_grant, 0);
    force_full = 0;
    tick();
    chk("unfull_grant", last_grant, 4'b0001);
    rq = 4'b0100;
    tick();
    chk("ptr_set", last_grant, 4'b0100);
    force_full = 1;
    rq = 4'b1001;
    tick();
    chk("full_grant3", last_grant, 0);
    force_full = 0;
    tick();
    chk("ptr_held", last_grant, 4'b1000);
    rq = '0;
    do_reset();
    // wrapping sum held until accepted
    bus.ResReady = 0;
    push1(32'd1);
    push1(32'd2);
    push1(32'd3);
    push1(32'hFFFF_FFFF);
    wait_valid(10);
    chk("wrap_sum", bus.ResData, 32'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", bus.ResValid, 1);
      chk("hold_data", bus.ResData, 32'd5);
    end
    bus.ResReady = 1;
    tick();
    chk("drain_valid", bus.ResValid, 0);
    // reset mid-accumulation discards the partial sum
    push1(32'd5);
    push1(32'd6);
    tick();
    do_reset();
    bus.ResReady = 0;
    push1(32'd10);
    push1(32'd20);
    push1(32'd30);
    push1(32'd40);
    wait_valid(10);
    chk("post_rst_sum", bus.ResData, 32'd100);
    bus.ResReady = 1;
    tick();
    do_reset();
    // clock-enable gap mid-accumulation
    bus.ResReady = 0;
    push1(32'd7);
    push1(32'd8);
    clk_en = 0;
    rq = 4'b0001;
    bus.ReqData[0 +: DW] = 32'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_grant", last_grant, 0);
      chk("gap_pop", last_pop, 0);
    end
    clk_en = 1;
    push1(32'd9);
    push1(32'd10);
    wait_valid(10);
    chk("gap_sum", bus.ResData, 32'd34);
    bus.ResReady = 1;
    tick();
    do_reset();
    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!rq[i] && $urandom_range(1, 0) == 1) begin
          rq[i] = 1'b1;
          bus.ReqData[i*DW +: DW] = $urandom;
        end
      clk_en = ($urandom_range(9, 0) != 0);
      force_full = ($urandom_range(9, 0) == 0);
      bus.ResReady = $urandom_range(1, 0);
      tick();
      rq = rq & ~last_grant;
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
